// File: rtl/clk_rate_det.sv
// -----------------------------------------------------------------------------
// clk_rate_det
//
// Measures the period of div_clk in clk_in cycles, locks once the period has
// been stable for LOCK_N consecutive periods, and reports the locked period.
//
// Parameters
//   CNT_W   period counter width
//   LOCK_N  consecutive in-tolerance periods needed to lock (>= 1)
//   TOL     allowed absolute deviation from the reference period
//
// Ports
//   clk_in        in   system clock, all logic on its rising edge
//   resetb        in   asynchronous active-low reset
//   div_clk       in   clock under measurement, asynchronous to clk_in
//   rise_stb      out  one-cycle strobe per detected div_clk rising edge
//   period        out  last accepted period while locked (clk_in cycles)
//   period_valid  out  one-cycle pulse whenever period is updated
//   locked        out  high while locked
//   timeout       out  one-cycle pulse when the counter saturates while active
// -----------------------------------------------------------------------------
module clk_rate_det #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4,
    parameter int TOL    = 1
) (
    input  logic             clk_in,
    input  logic             resetb,
    input  logic             div_clk,
    output logic             rise_stb,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int                 MATCH_W    = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   TOL_C      = CNT_W'(TOL);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAS,
        ST_ACQ,
        ST_LOCK
    } state_t;

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    state_t             state_q, state_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               s3_q, s3_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ref_q, ref_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               rise_q, rise_d;
    logic               pv_q, pv_d;
    logic               locked_q, locked_d;
    logic               tmo_q, tmo_d;

    logic               ev;
    logic               sat;
    logic               hit;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_comb begin
        s1_d = div_clk;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    assign ev  = s2_q & ~s3_q;
    // The counter reaches all-ones on this edge. Flagging it one edge early
    // makes timeout coincide with the edge where cnt becomes all-ones; an
    // event always restarts the count, so sat and ev never fight.
    assign sat = ~ev & (cnt_q == (CNT_MAX - CNT_W'(1)));
    assign hit = (abs_diff(cnt_q, ref_q) <= TOL_C);

    // Period counter: restart at 1 on an event, otherwise count and saturate.
    always_comb begin
        if (ev) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        match_d  = match_q;
        period_d = period_q;
        locked_d = locked_q;
        pv_d     = 1'b0;
        tmo_d    = 1'b0;
        rise_d   = ev;

        if ((state_q != ST_IDLE) && sat) begin
            state_d  = ST_IDLE;
            locked_d = 1'b0;
            tmo_d    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev) begin
                        state_d = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (ev) begin
                        state_d = ST_ACQ;
                        ref_d   = cnt_q;
                        match_d = '0;
                    end
                end
                ST_ACQ: begin
                    if (ev) begin
                        if (hit) begin
                            if (match_q == MATCH_LAST) begin
                                state_d  = ST_LOCK;
                                locked_d = 1'b1;
                                period_d = cnt_q;
                                pv_d     = 1'b1;
                            end else begin
                                match_d = match_q + MATCH_W'(1);
                            end
                        end else begin
                            ref_d   = cnt_q;
                            match_d = '0;
                        end
                    end
                end
                ST_LOCK: begin
                    // The reference stays fixed while locked so that slow
                    // drift cannot walk it away from the acquired rate.
                    if (ev) begin
                        if (hit) begin
                            period_d = cnt_q;
                            pv_d     = 1'b1;
                        end else begin
                            state_d  = ST_ACQ;
                            locked_d = 1'b0;
                            ref_d    = cnt_q;
                            match_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            ref_q    <= '0;
            match_q  <= '0;
            period_q <= '0;
            rise_q   <= 1'b0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            cnt_q    <= cnt_d;
            ref_q    <= ref_d;
            match_q  <= match_d;
            period_q <= period_d;
            rise_q   <= rise_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            tmo_q    <= tmo_d;
        end
    end

    assign rise_stb     = rise_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign timeout      = tmo_q;

endmodule

// File: tb/tb_clk_rate_det.sv
// -----------------------------------------------------------------------------
// tb_clk_rate_det
//
// Directed bench for clk_rate_det. A behavioural model tracks div_clk rising
// edges as event times and derives lock/period/timeout from the period
// history; every cycle the DUT outputs are compared against it. Literal
// expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_clk_rate_det;

    localparam int CNT_W  = 8;
    localparam int LOCK_N = 4;
    localparam int TOL    = 1;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic             clk_in  = 1'b0;
    logic             resetb  = 1'b0;
    logic             div_clk = 1'b0;
    logic             rise_stb;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    int errors = 0;
    int checks = 0;

    // model state
    logic d1, d2, d3;
    int   cyc_n;
    bit   armed;
    int   ref_p;
    int   streak;
    bit   m_lk;
    int   m_per;
    int   last_ev;
    bit   e_rise, e_pv, e_to;

    // observation statistics for literal checks
    int   gap;
    int   to_gap;
    int   to_cnt;
    bit   lock_seen;

    clk_rate_det #(
        .CNT_W (CNT_W),
        .LOCK_N(LOCK_N),
        .TOL   (TOL)
    ) dut (
        .clk_in      (clk_in),
        .resetb      (resetb),
        .div_clk     (div_clk),
        .rise_stb    (rise_stb),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 400000", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d required %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
        armed = 1'b0; ref_p = -1; streak = 0; m_lk = 1'b0; m_per = 0;
        e_rise = 1'b0; e_pv = 1'b0; e_to = 1'b0;
    endtask

    // One clk_in edge of the model. A div_clk level first sampled high at edge
    // k (low at k-1) is an event at edge k+2.
    task automatic model_step();
        bit ev;
        int m, dev;
        cyc_n++;
        ev = d2 & ~d3;
        d3 = d2; d2 = d1; d1 = div_clk;
        e_rise = ev; e_pv = 1'b0; e_to = 1'b0;
        if (armed && !ev && (cyc_n - last_ev) == MAXC - 1) begin
            armed = 1'b0; ref_p = -1; m_lk = 1'b0; e_to = 1'b1;
        end else if (ev) begin
            m = cyc_n - last_ev;
            if (!armed) begin
                armed = 1'b1;
            end else if (ref_p < 0) begin
                ref_p = m; streak = 0;
            end else begin
                dev = (m > ref_p) ? m - ref_p : ref_p - m;
                if (dev <= TOL) begin
                    if (m_lk) begin
                        m_per = m; e_pv = 1'b1;
                    end else begin
                        streak++;
                        if (streak == LOCK_N) begin
                            m_lk = 1'b1; m_per = m; e_pv = 1'b1;
                        end
                    end
                end else begin
                    ref_p = m; streak = 0; m_lk = 1'b0;
                end
            end
            last_ev = cyc_n;
        end
    endtask

    task automatic compare();
        chk("rise_stb",     32'(rise_stb),     32'(e_rise));
        chk("period_valid", 32'(period_valid), 32'(e_pv));
        chk("timeout",      32'(timeout),      32'(e_to));
        chk("locked",       32'(locked),       32'(m_lk));
        chk("period",       32'(period),       32'(m_per));
        chk("pv_to_excl",   32'(period_valid & timeout), 32'd0);
    endtask

    task automatic cyc2(input logic d, input logic rb);
        @(negedge clk_in);
        div_clk = d;
        resetb  = rb;
        @(posedge clk_in);
        if (resetb) model_step();
        else        model_clear();
        #1;
        compare();
        if (rise_stb) gap = 0;
        else          gap++;
        if (timeout) begin
            to_gap = gap;
            to_cnt++;
        end
        if (locked) lock_seen = 1'b1;
    endtask

    task automatic cyc(input logic d);
        cyc2(d, 1'b1);
    endtask

    // n periods of length p: high for the first p/2 cycles, then low.
    task automatic run(input int p, input int n);
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < p; i++) begin
                cyc(i < p / 2);
            end
        end
    endtask

    initial begin
        cyc_n = 0; last_ev = 0; gap = 0; to_gap = 0; to_cnt = 0; lock_seen = 1'b0;
        model_clear();

        // reset state
        for (int i = 0; i < 3; i++) cyc2(1'b0, 1'b0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        cyc2(1'b0, 1'b1);

        // constant period 64: lock on the 6th rising edge
        run(64, 5);
        chk("p64_not_locked_r5", 32'(locked), 32'd0);
        run(64, 1);
        chk("p64_locked_r6", 32'(locked), 32'd1);
        chk("p64_period_r6", 32'(period), 32'd64);

        // jitter within tolerance
        run(65, 1); run(63, 1); run(64, 1); run(65, 1);
        chk("jit_locked", 32'(locked), 32'd1);
        chk("jit_period", 32'(period), 32'd64);
        run(32, 1);
        chk("jit_last_period", 32'(period), 32'd65);

        // rate change to 32: unlock, then relock after 4 more periods
        run(32, 1);
        chk("p32_unlocked", 32'(locked), 32'd0);
        chk("p32_period_hold", 32'(period), 32'd65);
        run(32, 4);
        chk("p32_relocked", 32'(locked), 32'd1);
        chk("p32_period", 32'(period), 32'd32);

        // back to 64, then stop div_clk
        run(64, 6);
        chk("p64b_locked", 32'(locked), 32'd1);
        run(64, 1);
        to_cnt = 0;
        for (int i = 0; i < 300; i++) cyc(1'b0);
        chk("stop_to_gap", 32'(to_gap), 32'd254);
        chk("stop_to_cnt", 32'(to_cnt), 32'd1);
        chk("stop_locked", 32'(locked), 32'd0);
        chk("stop_period", 32'(period), 32'd64);

        // async reset mid-lock
        run(64, 7);
        chk("pre_rst_locked", 32'(locked), 32'd1);
        for (int i = 0; i < 5; i++) cyc(1'b0);
        #3;
        resetb = 1'b0;
        #1;
        model_clear();
        compare();
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_period", 32'(period), 32'd0);
        cyc2(1'b0, 1'b0);
        cyc2(1'b0, 1'b0);
        cyc2(1'b0, 1'b1);
        run(64, 5);
        chk("arst_relock_r5", 32'(locked), 32'd0);
        run(64, 1);
        chk("arst_relock_r6", 32'(locked), 32'd1);
        chk("arst_relock_per", 32'(period), 32'd64);

        // minimum period of 2
        run(2, 8);
        chk("p2_locked", 32'(locked), 32'd1);
        chk("p2_period", 32'(period), 32'd2);

        // period 300 exceeds the counter: repeated timeouts, never locks
        run(300, 1);
        chk("p300_first_drop", 32'(locked), 32'd0);
        to_cnt = 0;
        lock_seen = 1'b0;
        run(300, 3);
        chk("p300_to_cnt", 32'(to_cnt), 32'd3);
        chk("p300_never_lock", 32'(lock_seen), 32'd0);
        chk("p300_period_hold", 32'(period), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
